tt_sweep_ctrl: RTL and testbench

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

---
 rtl/tt_sweep_pkg.sv | 20 ++
 rtl/tt_expect.sv | 21 ++
 rtl/tt_sweep_ctrl.sv | 124 ++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;

    // Sweep controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Gate functions the attached 3-input gate is expected to implement
    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;

    // Number of input vectors in one sweep (all combinations of a, b, c)
    localparam int NUM_VEC = 8;

endpackage

// File: rtl/tt_expect.sv
// Combinational golden value of the gate under test for one input vector.
module tt_expect
    import tt_sweep_pkg::*;
(
    input  logic [1:0] op,
    input  logic [2:0] vec,
    output logic       exp
);

    // Reduce the vector according to the selected gate function
    always_comb begin
        exp = 1'b0;
        case (op)
            OP_AND:  exp = &vec;
            OP_OR:   exp = |vec;
            OP_XOR:  exp = ^vec;
            default: exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Drives all eight input vectors into a 3-input gate, samples its output,
// builds the truth table and counts mismatches against the expected function.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [1:0] GATE_OP     = OP_AND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] tt,
    output logic [2:0] vec
);

    // Hold counter is loaded with HOLD_CYCLES-1 and leaves DRIVE when it reaches 0
    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] LAST_VEC    = 3'(NUM_VEC - 1);

    state_e     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic [7:0] tt_q, tt_d;
    logic       pass_q, pass_d;
    logic       exp_bit;

    tt_expect u_expect (
        .op  (GATE_OP),
        .vec (vec_q),
        .exp (exp_bit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start is only looked at in IDLE so it is never queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_DRIVE;
            ST_DRIVE:  if (hold_q == 8'd0) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (vec_q == LAST_VEC) ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath registers: vector index, hold counter, results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q     <= 3'd0;
            hold_q    <= 8'd0;
            err_cnt_q <= 4'd0;
            tt_q      <= 8'd0;
            pass_q    <= 1'b0;
        end else begin
            vec_q     <= vec_d;
            hold_q    <= hold_d;
            err_cnt_q <= err_cnt_d;
            tt_q      <= tt_d;
            pass_q    <= pass_d;
        end
    end

    // Datapath updates; results hold everywhere except start acceptance and SAMPLE
    always_comb begin
        vec_d     = vec_q;
        hold_d    = hold_q;
        err_cnt_d = err_cnt_q;
        tt_d      = tt_q;
        pass_d    = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d     = 3'd0;
                    err_cnt_d = 4'd0;
                    tt_d      = 8'd0;
                    pass_d    = 1'b0;
                    hold_d    = HOLD_RELOAD;
                end
            end
            ST_DRIVE: begin
                if (hold_q != 8'd0) hold_d = hold_q - 8'd1;
            end
            ST_SAMPLE: begin
                tt_d[vec_q] = y;
                // At most eight mismatches, so the 4-bit count cannot wrap
                if (y != exp_bit) err_cnt_d = err_cnt_q + 4'd1;
                if (vec_q != LAST_VEC) begin
                    vec_d  = vec_q + 3'd1;
                    hold_d = HOLD_RELOAD;
                end else begin
                    // Verdict is taken with the last comparison folded in, so it is valid alongside done
                    pass_d = (err_cnt_d == 4'd0);
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; gate inputs are parked at 0 outside the sweep
    always_comb begin
        busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
        done      = (state_q == ST_DONE);
        {c, b, a} = busy ? vec_q : 3'd0;
        vec       = vec_q;
        err_cnt   = err_cnt_q;
        tt        = tt_q;
        pass      = pass_q;
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Randomized self-checking bench: two controllers (AND/hold 4, XOR/hold 1)
// each driving a table-defined gate, checked against a truth-table model.
module tb_tt_sweep_ctrl;
    import tt_sweep_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      start;
    logic [1:0]      a_o, b_o, c_o, y;
    logic [1:0]      busy, done, pass;
    logic [1:0][3:0] err;
    logic [1:0][7:0] tt;
    logic [1:0][2:0] vec;
    logic [1:0][7:0] gtbl;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Attached gate: output for vector {c,b,a} is read from a lookup table
    assign y[0] = gtbl[0][{c_o[0], b_o[0], a_o[0]}];
    assign y[1] = gtbl[1][{c_o[1], b_o[1], a_o[1]}];

    tt_sweep_ctrl #(.HOLD_CYCLES(4), .GATE_OP(OP_AND)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .a(a_o[0]), .b(b_o[0]), .c(c_o[0]), .y(y[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_cnt(err[0]), .tt(tt[0]), .vec(vec[0])
    );

    tt_sweep_ctrl #(.HOLD_CYCLES(1), .GATE_OP(OP_XOR)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .a(a_o[1]), .b(b_o[1]), .c(c_o[1]), .y(y[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_cnt(err[1]), .tt(tt[1]), .vec(vec[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ideal truth table of a gate function, built vector by vector
    function automatic logic [7:0] ref_tbl(input logic [1:0] op);
        logic [7:0] t;
        t = 8'h00;
        for (int v = 0; v < 8; v++) begin
            if (op == OP_AND)     t[v] = (v == 7);
            else if (op == OP_OR) t[v] = (v != 0);
            else                  t[v] = ($countones(v) % 2 == 1);
        end
        return t;
    endfunction

    // One full sweep on controller d; caller is at a negedge with the DUT idle.
    // mid: random start pulses while busy; dc: start pulse in the done cycle.
    task automatic sweep(input int d, input int h, input logic [7:0] ref_t,
                         input logic [7:0] g, input bit mid, input bit dc, input string tag);
        int         len;
        int         ev;
        logic [3:0] e_err;
        len   = 8 * (h + 1);
        e_err = 4'($countones(g ^ ref_t));
        gtbl[d]  = g;
        start[d] = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            start[d] = mid ? 1'($urandom_range(0, 1)) : 1'b0;
            ev = (k - 1) / (h + 1);
            chk({tag, ".busy"}, 32'(busy[d]), 32'd1);
            chk({tag, ".done_early"}, 32'(done[d]), 32'd0);
            chk({tag, ".vec"}, 32'(vec[d]), 32'(ev));
            chk({tag, ".abc"}, 32'({c_o[d], b_o[d], a_o[d]}), 32'(ev));
        end
        @(negedge clk);
        start[d] = dc;
        chk({tag, ".done"}, 32'(done[d]), 32'd1);
        chk({tag, ".busy_done"}, 32'(busy[d]), 32'd0);
        chk({tag, ".abc_done"}, 32'({c_o[d], b_o[d], a_o[d]}), 32'd0);
        chk({tag, ".tt"}, 32'(tt[d]), 32'(g));
        chk({tag, ".err"}, 32'(err[d]), 32'(e_err));
        chk({tag, ".pass"}, 32'(pass[d]), 32'(e_err == 4'd0));
        @(negedge clk);
        start[d] = 1'b0;
        chk({tag, ".done_pulse"}, 32'(done[d]), 32'd0);
        chk({tag, ".busy_gap"}, 32'(busy[d]), 32'd0);
        @(negedge clk);
        chk({tag, ".no_queue"}, 32'(busy[d]), 32'd0);
        chk({tag, ".tt_hold"}, 32'(tt[d]), 32'(g));
        chk({tag, ".err_hold"}, 32'(err[d]), 32'(e_err));
        chk({tag, ".pass_hold"}, 32'(pass[d]), 32'(e_err == 4'd0));
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, ".abc"}, 32'({c_o[d], b_o[d], a_o[d]}), 32'd0);
        chk({tag, ".busy"}, 32'(busy[d]), 32'd0);
        chk({tag, ".done"}, 32'(done[d]), 32'd0);
        chk({tag, ".pass"}, 32'(pass[d]), 32'd0);
        chk({tag, ".err"}, 32'(err[d]), 32'd0);
        chk({tag, ".tt"}, 32'(tt[d]), 32'd0);
        chk({tag, ".vec"}, 32'(vec[d]), 32'd0);
    endtask

    initial begin
        logic [7:0] r_and, r_xor, g;
        r_and = ref_tbl(OP_AND);
        r_xor = ref_tbl(OP_XOR);
        rst   = 1'b1;
        start = 2'b00;
        gtbl  = '0;
        repeat (2) @(negedge clk);
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");
        rst = 1'b0;

        // Directed gates on the AND/hold-4 controller
        sweep(0, 4, r_and, 8'h80, 1'b0, 1'b0, "and_ok");
        sweep(0, 4, r_and, 8'h00, 1'b0, 1'b0, "stuck0");
        sweep(0, 4, r_and, 8'hFF, 1'b0, 1'b0, "stuck1");
        sweep(0, 4, r_and, 8'h88, 1'b1, 1'b1, "a_and_b");
        // Correct XOR on the XOR/hold-1 controller
        sweep(1, 1, r_xor, 8'h96, 1'b1, 1'b1, "xor_ok");
        sweep(1, 1, r_xor, 8'h69, 1'b0, 1'b0, "xnor");

        // Random gate tables with random ignored start pulses
        for (int i = 0; i < 6; i++) begin
            g = 8'($urandom);
            sweep(0, 4, r_and, g, 1'b1, 1'($urandom_range(0, 1)), "rnd0");
            g = 8'($urandom);
            sweep(1, 1, r_xor, g, 1'b1, 1'($urandom_range(0, 1)), "rnd1");
        end

        // Start held high: back-to-back sweeps with one idle cycle between
        gtbl[0]  = r_and;
        start[0] = 1'b1;
        repeat (41) @(negedge clk);
        chk("b2b.done", 32'(done[0]), 32'd1);
        @(negedge clk);
        chk("b2b.gap", 32'(busy[0]), 32'd0);
        chk("b2b.gap_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        start[0] = 1'b0;
        chk("b2b.relaunch", 32'(busy[0]), 32'd1);
        chk("b2b.vec0", 32'(vec[0]), 32'd0);
        repeat (20) @(negedge clk);
        chk("abort.vec4", 32'(vec[0]), 32'd4);
        chk("abort.abc4", 32'({c_o[0], b_o[0], a_o[0]}), 32'd4);

        // Asynchronous reset mid-sweep clears everything at once
        rst = 1'b1;
        #1;
        chk_zero(0, "abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort.no_done", 32'(done[0]), 32'd0);
            chk("abort.idle", 32'(busy[0]), 32'd0);
        end
        rst = 1'b0;
        sweep(0, 4, r_and, r_and, 1'b0, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
